// File: rtl/msk_g4seq_pkg.sv
// msk_g4seq_pkg: shared constants and the randomness-width helper for the G(4) multiplier sequencer
package msk_g4seq_pkg;
  localparam int G4SH = 2;
  localparam int FIFO_DEPTH = 2;
  function automatic int rnd_w(input int d);
    return 2 * d * (d - 1);
  endfunction
endpackage

// File: rtl/msk_shares_fifo2.sv
// msk_shares_fifo2: 2-entry share FIFO; MSK_G4SEQ_CLR_EN zeroes popped slots and blanks the head when empty
module msk_shares_fifo2
  import msk_g4seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_cnt,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic         r_wp, r_rp;
  logic [1:0]   r_cnt;
  // slot storage with 1-bit wrapping pointers; count tracks simultaneous push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '{default: '0};
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) r_mem[r_wp] <= i_din;
`ifdef MSK_G4SEQ_CLR_EN
      if (i_pop) r_mem[r_rp] <= '0;
`endif
      r_wp  <= r_wp ^ i_push;
      r_rp  <= r_rp ^ i_pop;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  assign o_cnt   = r_cnt;
  assign o_full  = r_cnt == 2'(FIFO_DEPTH);
  assign o_empty = r_cnt == 2'd0;
`ifdef MSK_G4SEQ_CLR_EN
  assign o_dout = o_empty ? '0 : r_mem[r_rp];
`else
  assign o_dout = r_mem[r_rp];
`endif
endmodule

// File: rtl/msk_g4mul_hpc3_seq.sv
// msk_g4mul_hpc3_seq: stream sequencer around one masked HPC3 G(4) multiplier; MSK_G4SEQ_CLR_EN clears popped FIFO slots
module msk_g4mul_hpc3_seq
  import msk_g4seq_pkg::*;
#(
  parameter int d     = 2,
  parameter int RND_W = rnd_w(d)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [d-1:0]     in_a0,
  input  logic [d-1:0]     in_a1,
  input  logic [d-1:0]     in_b0,
  input  logic [d-1:0]     in_b1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RND_W-1:0] rnd_in,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic [d-1:0]     mul_a0,
  output logic [d-1:0]     mul_a1,
  output logic [d-1:0]     mul_b0,
  output logic [d-1:0]     mul_b1,
  output logic [d-1:0]     mul_ap0,
  output logic [d-1:0]     mul_ap1,
  output logic [RND_W-1:0] mul_rnd,
  input  logic [d-1:0]     mul_o0,
  input  logic [d-1:0]     mul_o1,
  output logic [d-1:0]     out0,
  output logic [d-1:0]     out1,
  output logic             out_valid,
  input  logic             out_ready
);
  logic               r_op_v, r_infl;
  logic [d-1:0]       r_a0, r_a1, r_b0, r_b1, r_ap0, r_ap1;
  logic               w_issue, w_pop, w_full, w_empty;
  logic [1:0]         w_cnt;
  logic [G4SH*d-1:0]  w_dout;
  // issue only when the product will still find a free FIFO slot next cycle
  assign w_pop     = out_valid & out_ready;
  assign w_issue   = !rst && r_op_v && rnd_valid &&
                     ({1'b0, w_cnt} + {2'b0, r_infl} - {2'b0, w_pop} < 3'd2);
  assign in_ready  = !rst && (!r_op_v || w_issue);
  assign rnd_ready = w_issue;
  assign mul_a0    = w_issue ? r_a0 : '0;
  assign mul_a1    = w_issue ? r_a1 : '0;
  assign mul_b0    = w_issue ? r_b0 : '0;
  assign mul_b1    = w_issue ? r_b1 : '0;
  assign mul_rnd   = w_issue ? rnd_in : '0;
  assign mul_ap0   = r_ap0;
  assign mul_ap1   = r_ap1;
  assign out_valid = !w_empty;
  assign out0      = w_dout[d-1:0];
  assign out1      = w_dout[G4SH*d-1:d];
  // operand holding register, delayed-a copy for the multiplier, in-flight flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_v <= 1'b0;
      r_infl <= 1'b0;
      r_a0   <= '0;
      r_a1   <= '0;
      r_b0   <= '0;
      r_b1   <= '0;
      r_ap0  <= '0;
      r_ap1  <= '0;
    end else begin
      r_infl <= w_issue;
      r_ap0  <= mul_a0;
      r_ap1  <= mul_a1;
      if (in_valid && in_ready) begin
        r_op_v <= 1'b1;
        r_a0   <= in_a0;
        r_a1   <= in_a1;
        r_b0   <= in_b0;
        r_b1   <= in_b1;
      end else if (w_issue) begin
        r_op_v <= 1'b0;
      end
    end
  end
  msk_shares_fifo2 #(.W(G4SH*d)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_infl),
    .i_din  ({mul_o1, mul_o0}),
    .i_pop  (w_pop),
    .o_dout (w_dout),
    .o_cnt  (w_cnt),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  // the issue rule keeps a landing product from ever meeting a full FIFO
  assert property (@(posedge clk) disable iff (rst) !(r_infl && w_full));
endmodule

// File: tb/tb_msk_g4mul_hpc3_seq.sv
// tb_msk_g4mul_hpc3_seq: randomized scoreboard bench with a behavioural masked G(4) multiplier stand-in
module tb_msk_g4mul_hpc3_seq;
  localparam int D  = 2;
  localparam int RW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [D-1:0]  in_a0, in_a1, in_b0, in_b1;
  logic          in_valid, in_ready;
  logic [RW-1:0] rnd_in;
  logic          rnd_valid, rnd_ready;
  logic [D-1:0]  mul_a0, mul_a1, mul_b0, mul_b1, mul_ap0, mul_ap1;
  logic [RW-1:0] mul_rnd;
  logic [D-1:0]  mul_o0, mul_o1, out0, out1;
  logic          out_valid, out_ready;
  always #5 clk = ~clk;
  msk_g4mul_hpc3_seq #(.d(D), .RND_W(RW)) dut (
    .clk(clk), .rst(rst),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .in_valid(in_valid), .in_ready(in_ready),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .mul_a0(mul_a0), .mul_a1(mul_a1), .mul_b0(mul_b0), .mul_b1(mul_b1),
    .mul_ap0(mul_ap0), .mul_ap1(mul_ap1), .mul_rnd(mul_rnd),
    .mul_o0(mul_o0), .mul_o1(mul_o1),
    .out0(out0), .out1(out1), .out_valid(out_valid), .out_ready(out_ready)
  );
  // G(4) = GF(2)[x]/(x^2+x+1) via discrete logs: 1=w^0, 2=w^1, 3=w^2
  function automatic logic [1:0] gmul(input logic [1:0] x, input logic [1:0] y);
    int lg [4];
    logic [1:0] ex [3];
    lg = '{0, 0, 1, 2};
    ex = '{2'd1, 2'd2, 2'd3};
    if (x == 2'd0 || y == 2'd0) return 2'd0;
    return ex[(lg[x] + lg[y]) % 3];
  endfunction
  // multiplier stand-in: registers b and randomness, uses the delayed-a port, remasks the product
  logic [D-1:0]  m_b0, m_b1;
  logic [RW-1:0] m_r;
  logic [1:0]    m_p, m_m;
  always_ff @(posedge clk) begin
    m_b0 <= mul_b0;
    m_b1 <= mul_b1;
    m_r  <= mul_rnd;
  end
  always_comb begin
    m_p    = gmul({^mul_ap1, ^mul_ap0}, {^m_b1, ^m_b0});
    m_m    = m_r[1:0] ^ m_r[3:2];
    mul_o0 = {m_p[0] ^ m_m[0], m_m[0]};
    mul_o1 = {m_p[1] ^ m_m[1], m_m[1]};
  end
  int tests = 0;
  int fails = 0;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // transaction-level model: accepted, issued and popped counts decide readiness
  logic [1:0]    q [$];
  int            acc, iss, pops, ncyc;
  logic [7:0]    pend;
  logic [RW-1:0] last_rnd;
  bit            have_last = 0;
  bit            cons = 0;
  always @(negedge clk) begin
    bit pop, ei, er;
    ncyc++;
    if (rst) begin
      acc = 0; iss = 0; pops = 0; cons = 0;
      q.delete();
    end else begin
      pop = out_valid && out_ready;
      ei  = (acc > iss) && rnd_valid && (iss - pops - int'(pop) < 2);
      er  = (acc == iss) || ei;
      chk("rnd_ready", int'(rnd_ready), int'(ei));
      chk("in_ready", int'(in_ready), int'(er));
      if (ei) begin
        chk("mul_ops", int'({mul_a1, mul_a0, mul_b1, mul_b0}), int'(pend));
        chk("mul_rnd", int'(mul_rnd), int'(rnd_in));
        if (have_last) chk("rnd_fresh", int'(mul_rnd != last_rnd), 1);
        last_rnd = mul_rnd;
        have_last = 1;
      end else begin
        chk("mul_idle", int'({mul_a1, mul_a0, mul_b1, mul_b0, mul_rnd}), 0);
      end
      if (in_valid && er) begin
        q.push_back(gmul({^in_a1, ^in_a0}, {^in_b1, ^in_b0}));
        pend = {in_a1, in_a0, in_b1, in_b0};
        acc++;
      end
      iss  += int'(ei);
      pops += int'(pop);
      cons = rnd_valid && rnd_ready;
    end
  end
  // output monitor: every pop must match the oldest expected product
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %0d expected none at %0t", {^out1, ^out0}, $time);
      end else begin
        chk("product", int'({^out1, ^out0}), int'(q.pop_front()));
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
    if (cons) rnd_in = rnd_in + RW'($urandom_range(1, 15));
  endtask
  task automatic rand_op();
    in_a0 = D'($urandom); in_a1 = D'($urandom);
    in_b0 = D'($urandom); in_b1 = D'($urandom);
  endtask
  task automatic send(input logic [1:0] a0, input logic [1:0] a1, input logic [1:0] b0, input logic [1:0] b1);
    bit ok = 0;
    in_valid = 1'b1;
    in_a0 = a0; in_a1 = a1; in_b0 = b0; in_b1 = b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      cyc();
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask
  task automatic rsend();
    send(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
  endtask
  task automatic stream(input int n, input bit toggle, output int cycles);
    int sent = 0;
    int c = 0;
    bit acc_now;
    in_valid = 1'b1;
    rand_op();
    while (sent < n && c < 200) begin
      rnd_valid = toggle ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      acc_now = in_ready;
      sent += int'(acc_now);
      cyc();
      c++;
      if (sent == n) in_valid = 1'b0;
      else if (acc_now) rand_op();
    end
    if (sent < n) chk("stream_timeout", sent, n);
    in_valid = 1'b0;
    rnd_valid = 1'b1;
    cycles = c;
  endtask
  task automatic drain(input string nm);
    for (int k = 0; k < 40 && q.size() > 0; k++) cyc();
    cyc();
    @(negedge clk);
    chk({nm, "_queue_empty"}, q.size(), 0);
    chk({nm, "_out_valid_idle"}, int'(out_valid), 0);
    cyc();
  endtask
  task automatic reset_pulse(input int extra);
    out_ready = 1'b0;
    repeat (3) rsend();
    repeat (extra) cyc();
    in_valid = 1'b1;
    rand_op();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_out_valid_after_rst", int'(out_valid), 0);
    repeat (4) begin
      cyc();
      @(negedge clk);
      chk("t6_no_stale_output", int'(out_valid), 0);
    end
    cyc();
    repeat (2) rsend();
    drain("t6");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n, cycles, iss0;
    bit seen;
    in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b0; rnd_in = '0;
    rand_op();
    // T1: reset dominates a pending input
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_in_ready", int'(in_ready), 0);
    chk("t1_rnd_ready", int'(rnd_ready), 0);
    chk("t1_out_valid", int'(out_valid), 0);
    chk("t1_mul_zero", int'({mul_a0, mul_a1, mul_b0, mul_b1, mul_ap0, mul_ap1, mul_rnd}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    // T2: a = 3, b = 3 as share vectors, expected product w^4 = w = 2
    in_valid = 1'b1;
    in_a1 = 2'b01; in_a0 = 2'b10; in_b1 = 2'b10; in_b0 = 2'b10;
    @(negedge clk);
    chk("t2_accept", int'(in_ready), 1);
    n = 0;
    seen = 0;
    while (n < 10 && !seen) begin
      cyc();
      in_valid = 1'b0;
      n++;
      @(negedge clk);
      seen = out_valid;
    end
    chk("t2_latency", n, 3);
    chk("t2_product", int'({^out1, ^out0}), 2);
    drain("t2");
    // T3: back-to-back random stream, one accept per cycle
    stream(20, 1'b0, cycles);
    chk("t3_cycles", cycles, 20);
    drain("t3");
    // T4: backpressure fills both slots, then releases without loss
    out_ready = 1'b0;
    repeat (3) rsend();
    in_valid = 1'b1;
    in_a0 = 2'b01; in_a1 = 2'b10; in_b0 = 2'b11; in_b1 = 2'b01;
    repeat (4) begin
      @(negedge clk);
      chk("t4_in_ready_stall", int'(in_ready), 0);
      chk("t4_rnd_ready_stall", int'(rnd_ready), 0);
      cyc();
    end
    @(negedge clk);
    chk("t4_out_valid_full", int'(out_valid), 1);
    cyc();
    out_ready = 1'b1;
    send(2'b01, 2'b10, 2'b11, 2'b01);
    drain("t4");
    // T5: randomness valid toggles; each issue takes a distinct word
    iss0 = iss;
    stream(8, 1'b1, cycles);
    drain("t5");
    chk("t5_issues", iss - iss0, 8);
    // T6: reset with in-flight product, then with a full FIFO
    reset_pulse(0);
    reset_pulse(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
